// File: rtl/otter_dmem_arb_pkg.sv
// otter_dmem_arb_pkg: shared types for the OTTER data-port arbiter.
// Holds the FSM state, master ids, access sizes and the request bundle.
package otter_dmem_arb_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    RD_WAIT = 1'b1
  } state_e;

  typedef enum logic {
    M_CPU = 1'b0,
    M_DMA = 1'b1
  } mid_e;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] din;
    logic [1:0]  size;
    logic        sign;
  } req_t;

endpackage

// File: rtl/otter_dmem_arbiter_if.sv
// otter_dmem_arbiter_if: requester and memory-port bundle of the arbiter.
// slave = arbiter side, master = requesters plus memory side.
interface otter_dmem_arbiter_if;
  logic        M0_REQ;
  logic        M0_WE;
  logic [31:0] M0_ADDR;
  logic [31:0] M0_DIN;
  logic [1:0]  M0_SIZE;
  logic        M0_SIGN;
  logic        M0_GNT;
  logic        M0_RVALID;
  logic [31:0] M0_DOUT;

  logic        M1_REQ;
  logic        M1_WE;
  logic [31:0] M1_ADDR;
  logic [31:0] M1_DIN;
  logic [1:0]  M1_SIZE;
  logic        M1_SIGN;
  logic        M1_GNT;
  logic        M1_RVALID;
  logic [31:0] M1_DOUT;

  logic        MEM_RDEN2;
  logic        MEM_WE2;
  logic [31:0] MEM_ADDR2;
  logic [31:0] MEM_DIN2;
  logic [1:0]  MEM_SIZE;
  logic        MEM_SIGN;
  logic [31:0] MEM_DOUT2;

  modport slave (
    input  M0_REQ, M0_WE, M0_ADDR, M0_DIN,
    input  M0_SIZE, M0_SIGN,
    output M0_GNT, M0_RVALID, M0_DOUT,
    input  M1_REQ, M1_WE, M1_ADDR, M1_DIN,
    input  M1_SIZE, M1_SIGN,
    output M1_GNT, M1_RVALID, M1_DOUT,
    output MEM_RDEN2, MEM_WE2, MEM_ADDR2,
    output MEM_DIN2, MEM_SIZE, MEM_SIGN,
    input  MEM_DOUT2
  );

  modport master (
    output M0_REQ, M0_WE, M0_ADDR, M0_DIN,
    output M0_SIZE, M0_SIGN,
    input  M0_GNT, M0_RVALID, M0_DOUT,
    output M1_REQ, M1_WE, M1_ADDR, M1_DIN,
    output M1_SIZE, M1_SIGN,
    input  M1_GNT, M1_RVALID, M1_DOUT,
    input  MEM_RDEN2, MEM_WE2, MEM_ADDR2,
    input  MEM_DIN2, MEM_SIZE, MEM_SIGN,
    output MEM_DOUT2
  );
endinterface

// File: rtl/otter_dmem_arb_pick.sv
// otter_dmem_arb_pick: combinational winner select.
// M0 has priority unless a starved M1 is owed the grant.
module otter_dmem_arb_pick
  import otter_dmem_arb_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic       m0_req_i,
  input  logic       m1_req_i,
  input  logic [3:0] starve_cnt_i,
  output logic       m0_win_o,
  output logic       m1_win_o
);
  localparam logic [3:0] SMAX = 4'(STARVE_MAX);

  logic force_m1;

  assign force_m1 = m1_req_i && (starve_cnt_i == SMAX);
  assign m0_win_o = m0_req_i && !force_m1;
  assign m1_win_o = m1_req_i && !m0_win_o;
endmodule

// File: rtl/otter_dmem_arbiter.sv
// otter_dmem_arbiter: shares OTTER memory port 2 between CPU (M0) and DMA (M1).
// Define OTTER_DMEM_ARB_MMIO_GUARD_EN to block M1 stores into MMIO space.
module otter_dmem_arbiter
  import otter_dmem_arb_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 4
`ifdef OTTER_DMEM_ARB_MMIO_GUARD_EN
  ,
  parameter logic [31:0] MMIO_BASE = 32'h0001_0000
`endif
) (
  input  logic CLK,
  input  logic RST_N,
  otter_dmem_arbiter_if.slave bus,
  output logic BUSY
`ifdef OTTER_DMEM_ARB_MMIO_GUARD_EN
  ,
  output logic M1_MMIO_ERR
`endif
);
  localparam logic [3:0] SMAX = 4'(STARVE_MAX);

  state_e      state_q, state_d;
  logic [3:0]  starve_q, starve_d;
  logic [31:0] laddr_q, laddr_d;
  logic [1:0]  lsize_q, lsize_d;
  logic        lsign_q, lsign_d;
  mid_e        lmid_q, lmid_d;
  logic        m0_rv_q, m0_rv_d;
  logic        m1_rv_q, m1_rv_d;
  logic [31:0] m0_dout_q, m0_dout_d;
  logic [31:0] m1_dout_q, m1_dout_d;
`ifdef OTTER_DMEM_ARB_MMIO_GUARD_EN
  logic        err_q, err_d;
`endif

  logic        m0_win, m1_win;
  req_t        r0, r1, win;
  logic        gnt0, gnt1;
  logic        rden, we, sign;
  logic [31:0] addr, din;
  logic [1:0]  size;

  assign r0 = '{we: bus.M0_WE, addr: bus.M0_ADDR,
                din: bus.M0_DIN, size: bus.M0_SIZE,
                sign: bus.M0_SIGN};
  assign r1 = '{we: bus.M1_WE, addr: bus.M1_ADDR,
                din: bus.M1_DIN, size: bus.M1_SIZE,
                sign: bus.M1_SIGN};

  otter_dmem_arb_pick #(
    .STARVE_MAX(STARVE_MAX)
  ) u_pick (
    .m0_req_i    (bus.M0_REQ),
    .m1_req_i    (bus.M1_REQ),
    .starve_cnt_i(starve_q),
    .m0_win_o    (m0_win),
    .m1_win_o    (m1_win)
  );

  always_comb begin
    state_d   = state_q;
    starve_d  = starve_q;
    laddr_d   = laddr_q;
    lsize_d   = lsize_q;
    lsign_d   = lsign_q;
    lmid_d    = lmid_q;
    m0_rv_d   = 1'b0;
    m1_rv_d   = 1'b0;
    m0_dout_d = m0_dout_q;
    m1_dout_d = m1_dout_q;
`ifdef OTTER_DMEM_ARB_MMIO_GUARD_EN
    err_d     = err_q;
`endif
    win  = '0;
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    rden = 1'b0;
    we   = 1'b0;
    addr = '0;
    din  = '0;
    size = '0;
    sign = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (m0_win || m1_win) begin
          win  = m1_win ? r1 : r0;
          gnt0 = m0_win;
          gnt1 = m1_win;
          addr = win.addr;
          din  = win.din;
          size = win.size;
          sign = win.sign;
          if (win.we) begin
            we = 1'b1;
`ifdef OTTER_DMEM_ARB_MMIO_GUARD_EN
            // DMA may not poke IO: grant, but drop the write
            if (m1_win && win.addr >= MMIO_BASE) begin
              we    = 1'b0;
              err_d = 1'b1;
            end
`endif
          end else begin
            rden    = 1'b1;
            laddr_d = win.addr;
            lsize_d = win.size;
            lsign_d = win.sign;
            lmid_d  = m1_win ? M_DMA : M_CPU;
            state_d = RD_WAIT;
          end
        end
        if (bus.M1_REQ) begin
          if (m1_win) begin
            starve_d = '0;
          end else if (starve_q != SMAX) begin
            starve_d = starve_q + 4'd1;
          end
        end
      end
      RD_WAIT: begin
        // memory sizes DOUT2 from the live port, so keep it steady
        addr    = laddr_q;
        size    = lsize_q;
        sign    = lsign_q;
        state_d = IDLE;
        if (lmid_q == M_DMA) begin
          m1_rv_d   = 1'b1;
          m1_dout_d = bus.MEM_DOUT2;
        end else begin
          m0_rv_d   = 1'b1;
          m0_dout_d = bus.MEM_DOUT2;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= IDLE;
      starve_q  <= '0;
      laddr_q   <= '0;
      lsize_q   <= '0;
      lsign_q   <= 1'b0;
      lmid_q    <= M_CPU;
      m0_rv_q   <= 1'b0;
      m1_rv_q   <= 1'b0;
      m0_dout_q <= '0;
      m1_dout_q <= '0;
`ifdef OTTER_DMEM_ARB_MMIO_GUARD_EN
      err_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      starve_q  <= starve_d;
      laddr_q   <= laddr_d;
      lsize_q   <= lsize_d;
      lsign_q   <= lsign_d;
      lmid_q    <= lmid_d;
      m0_rv_q   <= m0_rv_d;
      m1_rv_q   <= m1_rv_d;
      m0_dout_q <= m0_dout_d;
      m1_dout_q <= m1_dout_d;
`ifdef OTTER_DMEM_ARB_MMIO_GUARD_EN
      err_q     <= err_d;
`endif
    end
  end

  assign bus.M0_GNT    = gnt0;
  assign bus.M1_GNT    = gnt1;
  assign bus.M0_RVALID = m0_rv_q;
  assign bus.M1_RVALID = m1_rv_q;
  assign bus.M0_DOUT   = m0_dout_q;
  assign bus.M1_DOUT   = m1_dout_q;
  assign bus.MEM_RDEN2 = rden;
  assign bus.MEM_WE2   = we;
  assign bus.MEM_ADDR2 = addr;
  assign bus.MEM_DIN2  = din;
  assign bus.MEM_SIZE  = size;
  assign bus.MEM_SIGN  = sign;
  assign BUSY          = (state_q == RD_WAIT);
`ifdef OTTER_DMEM_ARB_MMIO_GUARD_EN
  assign M1_MMIO_ERR   = err_q;
`endif
endmodule

// File: tb/tb_otter_dmem_arbiter.sv
// tb_otter_dmem_arbiter: directed and randomized checks of the arbiter
// against a byte-level reference memory and a grant-order model.
module tb_otter_dmem_arbiter;
  import otter_dmem_arb_pkg::*;

  localparam int SMAX = 4;

  logic CLK = 1'b0;
  logic RST_N = 1'b0;
  logic BUSY;
`ifdef OTTER_DMEM_ARB_MMIO_GUARD_EN
  logic M1_MMIO_ERR;
`endif

  otter_dmem_arbiter_if bus ();

  always #5 CLK = ~CLK;

  otter_dmem_arbiter #(
    .STARVE_MAX(SMAX)
  ) dut (
    .CLK  (CLK),
    .RST_N(RST_N),
    .bus  (bus),
    .BUSY (BUSY)
`ifdef OTTER_DMEM_ARB_MMIO_GUARD_EN
    ,
    .M1_MMIO_ERR(M1_MMIO_ERR)
`endif
  );

  // ---- BRAM-like memory: registered word, combinational sizing
  logic [31:0] mem_w [0:1023];
  logic [31:0] rd_word = '0;

  function automatic logic [31:0] merge(
    input logic [31:0] old, input logic [31:0] d,
    input logic [1:0] a, input logic [1:0] sz);
    logic [31:0] r;
    r = old;
    case (sz)
      2'd0: r[8*int'(a) +: 8] = d[7:0];
      2'd1: r[16*int'(a[1]) +: 16] = d[15:0];
      default: r = d;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] mem_fmt(
    input logic [31:0] w, input logic [1:0] a,
    input logic [1:0] sz, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[8*int'(a) +: 8];
    h = w[16*int'(a[1]) +: 16];
    case (sz)
      2'd0: return uns ? {24'b0, b} : {{24{b[7]}}, b};
      2'd1: return uns ? {16'b0, h} : {{16{h[15]}}, h};
      default: return w;
    endcase
  endfunction

  always @(posedge CLK) begin
    if (bus.MEM_RDEN2)
      rd_word <= mem_w[bus.MEM_ADDR2[11:2]];
    if (bus.MEM_WE2 && bus.MEM_ADDR2 < 32'h0001_0000)
      mem_w[bus.MEM_ADDR2[11:2]] <= merge(mem_w[bus.MEM_ADDR2[11:2]],
        bus.MEM_DIN2, bus.MEM_ADDR2[1:0], bus.MEM_SIZE);
  end

  assign bus.MEM_DOUT2 = mem_fmt(rd_word, bus.MEM_ADDR2[1:0],
                                 bus.MEM_SIZE, bus.MEM_SIGN);

  // ---- reference: flat byte store, arithmetic sign extension
  logic [7:0] ref_b [logic [31:0]];

  function automatic longint rbyte(input logic [31:0] a);
    return ref_b.exists(a) ? longint'(ref_b[a]) : 0;
  endfunction

  task automatic ref_store(input logic [31:0] a, input logic [31:0] d,
                           input logic [1:0] sz);
    int n;
    n = 1 << sz;
    if (a < 32'h0001_0000)
      for (int i = 0; i < n; i++) ref_b[a + 32'(i)] = d[8*i +: 8];
  endtask

  function automatic logic [31:0] ref_load(input logic [31:0] a,
                                           input logic [1:0] sz,
                                           input logic uns);
    int n;
    longint v;
    n = 1 << sz;
    v = 0;
    for (int i = 0; i < n; i++) v += rbyte(a + 32'(i)) << (8 * i);
    if (!uns && n < 4 && v >= (longint'(1) << (8 * n - 1)))
      v -= longint'(1) << (8 * n);
    return v[31:0];
  endfunction

  // ---- bookkeeping
  int tests = 0;
  int fails = 0;
  int loss = 0;
  int ng = 0;
  logic [31:0] gseq = '0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic req_t mk(input logic we, input logic [31:0] a,
                              input logic [31:0] d, input logic [1:0] sz,
                              input logic sg);
    req_t r;
    r.we = we; r.addr = a; r.din = d; r.size = sz; r.sign = sg;
    return r;
  endfunction

  function automatic req_t rand_req(input bit sat);
    req_t r;
    r.size = 2'($urandom_range(2));
    r.addr = 32'($urandom_range(255)) & ~((32'd1 << r.size) - 32'd1);
    r.we   = sat ? 1'b0 : 1'($urandom_range(1));
    r.din  = $urandom;
    r.sign = 1'($urandom_range(1));
    return r;
  endfunction

  task automatic drive(input int m, input req_t r, input logic v);
    if (m == 0) begin
      bus.M0_REQ = v; bus.M0_WE = r.we; bus.M0_ADDR = r.addr;
      bus.M0_DIN = r.din; bus.M0_SIZE = r.size; bus.M0_SIGN = r.sign;
    end else begin
      bus.M1_REQ = v; bus.M1_WE = r.we; bus.M1_ADDR = r.addr;
      bus.M1_DIN = r.din; bus.M1_SIZE = r.size; bus.M1_SIGN = r.sign;
    end
  endtask

  task automatic clr_req;
    drive(0, '0, 1'b0);
    drive(1, '0, 1'b0);
  endtask

  function automatic logic gnt(input int m);
    return (m == 0) ? bus.M0_GNT : bus.M1_GNT;
  endfunction

  task automatic do_store(input int m, input req_t r);
    @(negedge CLK);
    clr_req;
    drive(m, r, 1'b1);
    #1;
    chk("st_gnt", gnt(m), 1'b1);
    chk("st_other_gnt", gnt(1 - m), 1'b0);
    chk("st_we2", bus.MEM_WE2, 1'b1);
    chk("st_rden2", bus.MEM_RDEN2, 1'b0);
    chk("st_addr2", bus.MEM_ADDR2, r.addr);
    chk("st_din2", bus.MEM_DIN2, r.din);
    chk("st_busy", BUSY, 1'b0);
    ref_store(r.addr, r.din, r.size);
    if (m == 1) loss = 0;
  endtask

  task automatic do_load(input int m, input req_t r, output logic [31:0] x);
    x = ref_load(r.addr, r.size, r.sign);
    @(negedge CLK);
    clr_req;
    drive(m, r, 1'b1);
    #1;
    chk("ld_gnt", gnt(m), 1'b1);
    chk("ld_rden2", bus.MEM_RDEN2, 1'b1);
    chk("ld_we2", bus.MEM_WE2, 1'b0);
    chk("ld_addr2", bus.MEM_ADDR2, r.addr);
    if (m == 1) loss = 0;
    @(negedge CLK);
    clr_req;
    #1;
    chk("ld_wait_busy", BUSY, 1'b1);
    chk("ld_wait_addr2", bus.MEM_ADDR2, r.addr);
    chk("ld_wait_size", bus.MEM_SIZE, r.size);
    chk("ld_wait_rden2", bus.MEM_RDEN2, 1'b0);
    chk("ld_wait_rv", m == 0 ? bus.M0_RVALID : bus.M1_RVALID, 1'b0);
    @(negedge CLK);
    #1;
    chk("ld_rv", m == 0 ? bus.M0_RVALID : bus.M1_RVALID, 1'b1);
    chk("ld_dout", m == 0 ? bus.M0_DOUT : bus.M1_DOUT, x);
    chk("ld_rv_other", m == 0 ? bus.M1_RVALID : bus.M0_RVALID, 1'b0);
  endtask

  task automatic run_arb(input int ncyc, input bit sat);
    bit p0, p1, busy;
    logic e0, e1;
    req_t q0, q1, w;
    int due0, due1;
    logic [31:0] x0, x1;
    p0 = 0; p1 = 0; busy = 0;
    q0 = '0; q1 = '0; due0 = -10; due1 = -10; x0 = '0; x1 = '0;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge CLK);
      if (!p0 && (sat || $urandom_range(3) != 0)) begin
        q0 = rand_req(sat); p0 = 1;
      end
      if (!p1 && (sat || $urandom_range(3) != 0)) begin
        q1 = rand_req(sat); p1 = 1;
      end
      if (!sat && p1 && $urandom_range(15) == 0) p1 = 0;
      drive(0, q0, p0);
      drive(1, q1, p1);
      #1;
      e0 = !busy && p0 && !(p1 && loss == SMAX);
      e1 = !busy && p1 && !e0;
      chk("arb_gnt0", bus.M0_GNT, e0);
      chk("arb_gnt1", bus.M1_GNT, e1);
      chk("arb_busy", BUSY, busy);
      chk("arb_rv0", bus.M0_RVALID, due0 == c);
      chk("arb_rv1", bus.M1_RVALID, due1 == c);
      if (due0 == c) chk("arb_dout0", bus.M0_DOUT, x0);
      if (due1 == c) chk("arb_dout1", bus.M1_DOUT, x1);
      if (!busy && p1)
        loss = e1 ? 0 : (loss < SMAX ? loss + 1 : loss);
      busy = 0;
      if (e0 || e1) begin
        w = e1 ? q1 : q0;
        if (ng < 32) gseq[ng] = e1;
        ng++;
        if (w.we) begin
          ref_store(w.addr, w.din, w.size);
        end else begin
          busy = 1;
          if (e1) begin
            due1 = c + 2; x1 = ref_load(w.addr, w.size, w.sign);
          end else begin
            due0 = c + 2; x0 = ref_load(w.addr, w.size, w.sign);
          end
        end
        if (e1) p1 = 0;
        else p0 = 0;
      end
    end
    @(negedge CLK);
    clr_req;
    repeat (3) @(negedge CLK);
  endtask

  task automatic do_reset;
    @(negedge CLK);
    clr_req;
    RST_N = 1'b0;
    loss = 0;
    @(negedge CLK);
    RST_N = 1'b1;
  endtask

  logic [31:0] x;

  initial begin
    for (int i = 0; i < 1024; i++) mem_w[i] = '0;
    clr_req;
    repeat (2) @(negedge CLK);
    #1;
    chk("rst_busy", BUSY, 1'b0);
    chk("rst_gnt0", bus.M0_GNT, 1'b0);
    chk("rst_gnt1", bus.M1_GNT, 1'b0);
    chk("rst_rden2", bus.MEM_RDEN2, 1'b0);
    chk("rst_we2", bus.MEM_WE2, 1'b0);
    chk("rst_addr2", bus.MEM_ADDR2, 32'h0);
    chk("rst_rv0", bus.M0_RVALID, 1'b0);
    chk("rst_rv1", bus.M1_RVALID, 1'b0);
    chk("rst_dout0", bus.M0_DOUT, 32'h0);
    chk("rst_dout1", bus.M1_DOUT, 32'h0);
`ifdef OTTER_DMEM_ARB_MMIO_GUARD_EN
    chk("rst_mmio_err", M1_MMIO_ERR, 1'b0);
`endif
    RST_N = 1'b1;

    do_store(0, mk(1'b1, 32'h100, 32'hDEAD_BEEF, SZ_WORD, 1'b0));
    do_load(0, mk(1'b0, 32'h100, 32'h0, SZ_WORD, 1'b0), x);
    chk("lw_const", bus.M0_DOUT, 32'hDEAD_BEEF);

    do_store(0, mk(1'b1, 32'h100, 32'h8000_0000, SZ_WORD, 1'b0));
    do_load(0, mk(1'b0, 32'h103, 32'h0, SZ_BYTE, 1'b0), x);
    chk("lb_const", bus.M0_DOUT, 32'hFFFF_FF80);
    do_load(0, mk(1'b0, 32'h103, 32'h0, SZ_BYTE, 1'b1), x);
    chk("lbu_const", bus.M0_DOUT, 32'h0000_0080);

    do_store(1, mk(1'b1, 32'h40, 32'h1234_F00D, SZ_HALF, 1'b0));
    do_load(1, mk(1'b0, 32'h40, 32'h0, SZ_HALF, 1'b0), x);
    chk("lh_const", bus.M1_DOUT, 32'hFFFF_F00D);
    chk("dout0_held", bus.M0_DOUT, 32'h0000_0080);

    do_store(1, mk(1'b1, 32'h200, 32'h1111_1111, SZ_WORD, 1'b0));
    do_store(1, mk(1'b1, 32'h204, 32'h2222_2222, SZ_WORD, 1'b0));
    do_store(1, mk(1'b1, 32'h208, 32'h3333_3333, SZ_WORD, 1'b0));
    do_load(1, mk(1'b0, 32'h204, 32'h0, SZ_WORD, 1'b1), x);
    chk("b2b_const", bus.M1_DOUT, 32'h2222_2222);

    do_reset;
    ng = 0;
    gseq = '0;
    run_arb(24, 1'b1);
    chk("sat_order", gseq[9:0], 10'b10_0001_0000);

    run_arb(400, 1'b0);

    @(negedge CLK);
    clr_req;
    drive(0, mk(1'b0, 32'h100, 32'h0, SZ_WORD, 1'b0), 1'b1);
    #1;
    chk("rst_mid_gnt", bus.M0_GNT, 1'b1);
    @(negedge CLK);
    clr_req;
    RST_N = 1'b0;
    loss = 0;
    #1;
    chk("rst_mid_busy", BUSY, 1'b0);
    chk("rst_mid_rv0", bus.M0_RVALID, 1'b0);
    chk("rst_mid_dout0", bus.M0_DOUT, 32'h0);
    chk("rst_mid_dout1", bus.M1_DOUT, 32'h0);
    chk("rst_mid_addr2", bus.MEM_ADDR2, 32'h0);
    chk("rst_mid_rden2", bus.MEM_RDEN2, 1'b0);
    @(negedge CLK);
    #1;
    chk("rst_hold_rv0", bus.M0_RVALID, 1'b0);
    RST_N = 1'b1;
    @(negedge CLK);
    #1;
    chk("rst_after_rv0", bus.M0_RVALID, 1'b0);
    do_load(0, mk(1'b0, 32'h204, 32'h0, SZ_WORD, 1'b0), x);

    @(negedge CLK);
    clr_req;
    drive(1, mk(1'b1, 32'h0001_1000, 32'hCAFE_0001, SZ_WORD, 1'b0), 1'b1);
    #1;
    chk("mmio_m1_gnt", bus.M1_GNT, 1'b1);
    loss = 0;
`ifdef OTTER_DMEM_ARB_MMIO_GUARD_EN
    chk("mmio_m1_we2", bus.MEM_WE2, 1'b0);
    @(negedge CLK);
    clr_req;
    #1;
    chk("mmio_err_set", M1_MMIO_ERR, 1'b1);
    @(negedge CLK);
    #1;
    chk("mmio_err_sticky", M1_MMIO_ERR, 1'b1);
`else
    chk("mmio_m1_we2", bus.MEM_WE2, 1'b1);
    chk("mmio_m1_addr2", bus.MEM_ADDR2, 32'h0001_1000);
`endif
    do_store(0, mk(1'b1, 32'h0001_1000, 32'hCAFE_0002, SZ_WORD, 1'b0));
    @(negedge CLK);
    clr_req;
`ifdef OTTER_DMEM_ARB_MMIO_GUARD_EN
    #1;
    chk("mmio_err_still", M1_MMIO_ERR, 1'b1);
`endif
    repeat (2) @(negedge CLK);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
